orb_packer_n: RTL and testbench

Parametrised multi-channel orbital-frame packer. It takes CH independent strobed byte streams and formats each byte into a telemetry word. It writes the words, interleaved by channel, into a shared frame RAM through a single write port. It succeeds the fixed two-channel packer, adding:
- configurable channel count, width and geometry;
- edge-based strobe capture;
- a delayed, round-robin-arbitrated single write port;
- per-channel overflow reporting.

---
 rtl/orb_packer_n.sv | 180 ++++++++++++++++++
 tb/tb_orb_packer_n.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/orb_packer_n.sv
// Multi-channel orbital-frame packer: strobed byte streams are formatted into telemetry
// words and written, channel-interleaved, into a shared frame RAM through one write port.
module orb_packer_n #(
    parameter int CH       = 2,
    parameter int DW       = 8,
    parameter int AW       = 11,
    parameter int GRP_LOG2 = 5,
    parameter int WPF      = 16,
    parameter int SKIP     = 2,
    parameter int WE_DLY   = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH*DW-1:0] iData,
    input  logic [CH-1:0]    strob,
    input  logic             SW,
    output logic [DW+3:0]    orbWord,
    output logic             WE,
    output logic [AW-1:0]    WrAddr,
    output logic             test,
    output logic [CH-1:0]    ovf
);
    localparam int WCW = (WPF + SKIP > 1) ? $clog2(WPF + SKIP) : 1;
    localparam int DCW = $clog2(WE_DLY + 1);
    localparam int PW  = (CH > 1) ? $clog2(CH) : 1;

    logic [CH-1:0]  strob_s1_q, strob_s2_q, strob_prev_q;
    logic           sw_s1_q, sw_s2_q, sw_prev_q;

    logic [WCW-1:0] w_q    [CH];
    logic [WCW-1:0] w_d    [CH];
    logic [AW-1:0]  g_q    [CH];
    logic [AW-1:0]  g_d    [CH];
    logic [DW-1:0]  data_q [CH];
    logic [DW-1:0]  data_d [CH];
    logic [AW-1:0]  addr_q [CH];
    logic [AW-1:0]  addr_d [CH];
    logic [DCW-1:0] dly_q  [CH];
    logic [DCW-1:0] dly_d  [CH];
    logic [CH-1:0]  pend_q, pend_d;
    logic [CH-1:0]  ovf_q, ovf_d;
    logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [DW+3:0]  word_hold_q, word_hold_d;
    logic [AW-1:0]  addr_hold_q, addr_hold_d;

    logic [CH-1:0]  cap;
    logic [CH-1:0]  ready;
    logic           sw_chg;
    logic           gnt_vld;
    logic [PW-1:0]  gnt_idx;
    logic [DW+3:0]  gnt_word;
    logic [31:0]    addr_full;
    int             idx;

    assign sw_chg = sw_s2_q ^ sw_prev_q;

    for (genvar gi = 0; gi < CH; gi++) begin : g_chan
        assign cap[gi]   = strob_s2_q[gi] & ~strob_prev_q[gi];
        assign ready[gi] = pend_q[gi] && (dly_q[gi] >= DCW'(WE_DLY - 1));
    end

    // Round-robin: scan from rr_ptr_q upwards, wrapping at CH.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int i = 0; i < CH; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= CH) idx = idx - CH;
            if (!gnt_vld && ready[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = PW'(idx);
            end
        end
    end

    // The write port is presented in the grant cycle itself so that an uncontended word
    // leaves exactly WE_DLY cycles after its capture; the hold registers keep the last value.
    assign WE       = gnt_vld & ~sw_chg;
    assign gnt_word = {1'b0, data_q[gnt_idx], 3'b000};
    assign orbWord  = WE ? gnt_word : word_hold_q;
    assign WrAddr   = WE ? addr_q[gnt_idx] : addr_hold_q;
    assign test     = sw_chg;
    assign ovf      = ovf_q;

    always_comb begin
        w_d         = w_q;
        g_d         = g_q;
        data_d      = data_q;
        addr_d      = addr_q;
        dly_d       = dly_q;
        pend_d      = pend_q;
        ovf_d       = ovf_q;
        rr_ptr_d    = rr_ptr_q;
        word_hold_d = word_hold_q;
        addr_hold_d = addr_hold_q;
        addr_full   = '0;
        if (WE) begin
            rr_ptr_d    = (int'(gnt_idx) == CH - 1) ? '0 : gnt_idx + 1'b1;
            word_hold_d = gnt_word;
            addr_hold_d = addr_q[gnt_idx];
        end
        for (int c = 0; c < CH; c++) begin
            if (pend_q[c] && (dly_q[c] < DCW'(WE_DLY - 1)))
                dly_d[c] = dly_q[c] + 1'b1;
            if (WE && (gnt_idx == PW'(c)))
                pend_d[c] = 1'b0;
            if (cap[c]) begin
                if (32'(w_q[c]) < WPF) begin
                    if (!pend_q[c]) begin
                        addr_full = (32'(g_q[c]) << GRP_LOG2) + 32'(c) + 32'(CH) * 32'(w_q[c]);
                        data_d[c] = iData[c*DW +: DW];
                        addr_d[c] = addr_full[AW-1:0];
                        pend_d[c] = 1'b1;
                        dly_d[c]  = '0;
                    end else begin
                        ovf_d[c] = 1'b1;
                    end
                end
                if (32'(w_q[c]) == WPF + SKIP - 1) begin
                    w_d[c] = '0;
                    g_d[c] = g_q[c] + 1'b1;
                end else begin
                    w_d[c] = w_q[c] + 1'b1;
                end
            end
        end
        // A frame switch overrides everything, including same-cycle captures.
        if (sw_chg) begin
            for (int c = 0; c < CH; c++) begin
                w_d[c]   = '0;
                g_d[c]   = '0;
                dly_d[c] = '0;
            end
            pend_d   = '0;
            ovf_d    = '0;
            rr_ptr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            strob_s1_q   <= '0;
            strob_s2_q   <= '0;
            strob_prev_q <= '0;
            sw_s1_q      <= 1'b0;
            sw_s2_q      <= 1'b0;
            sw_prev_q    <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                w_q[c]    <= '0;
                g_q[c]    <= '0;
                data_q[c] <= '0;
                addr_q[c] <= '0;
                dly_q[c]  <= '0;
            end
            pend_q      <= '0;
            ovf_q       <= '0;
            rr_ptr_q    <= '0;
            word_hold_q <= '0;
            addr_hold_q <= '0;
        end else begin
            strob_s1_q   <= strob;
            strob_s2_q   <= strob_s1_q;
            strob_prev_q <= strob_s2_q;
            sw_s1_q      <= SW;
            sw_s2_q      <= sw_s1_q;
            sw_prev_q    <= sw_s2_q;
            w_q          <= w_d;
            g_q          <= g_d;
            data_q       <= data_d;
            addr_q       <= addr_d;
            dly_q        <= dly_d;
            pend_q       <= pend_d;
            ovf_q        <= ovf_d;
            rr_ptr_q     <= rr_ptr_d;
            word_hold_q  <= word_hold_d;
            addr_hold_q  <= addr_hold_d;
        end
    end
endmodule

// File: tb/tb_orb_packer_n.sv
// Directed bench for orb_packer_n at its default geometry (CH=2, WE_DLY=28).
module tb_orb_packer_n;
    logic        clk;
    logic        rst;
    logic [15:0] iData;
    logic [1:0]  strob;
    logic        SW;
    logic [11:0] orbWord;
    logic        WE;
    logic [10:0] WrAddr;
    logic        test;
    logic [1:0]  ovf;

    int checks = 0;
    int errors = 0;

    orb_packer_n dut (
        .clk(clk), .rst(rst), .iData(iData), .strob(strob), .SW(SW),
        .orbWord(orbWord), .WE(WE), .WrAddr(WrAddr), .test(test), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe pin driven just after a falling edge: synced at edge 2, captured state at edge 3,
    // so an uncontended WE (capture + 28) is sampled after edge 30 of the window.
    localparam int LAT = 30;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Drives one strobe event and records up to two write-port transfers in a fixed window.
    task automatic pulse_watch(input logic [1:0] mask, input logic [15:0] dat, input int hold,
                               input int window, output int n_we, output int lat0, output int lat1,
                               output logic [10:0] a0, output logic [10:0] a1,
                               output logic [11:0] w0, output logic [11:0] w1);
        n_we = 0; lat0 = -1; lat1 = -1; a0 = '0; a1 = '0; w0 = '0; w1 = '0;
        @(negedge clk);
        iData = dat;
        strob = strob | mask;
        for (int n = 1; n <= window; n++) begin
            @(posedge clk);
            #1;
            if (n == hold) strob = strob & ~mask;
            if (WE) begin
                if (n_we == 0) begin lat0 = n; a0 = WrAddr; w0 = orbWord; end
                else if (n_we == 1) begin lat1 = n; a1 = WrAddr; w1 = orbWord; end
                n_we++;
            end
        end
        $display("strobe mask=%b data=%h: we=%0d lat=%0d addr=%0d word=%h", mask, dat, n_we, lat0, a0, w0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (WE !== 1'b0)        begin errors++; $display("FAIL reset_we got %b exp 0", WE); end
        checks++; if (WrAddr !== 11'd0)   begin errors++; $display("FAIL reset_addr got %h exp 0", WrAddr); end
        checks++; if (orbWord !== 12'd0)  begin errors++; $display("FAIL reset_word got %h exp 0", orbWord); end
        checks++; if (test !== 1'b0)      begin errors++; $display("FAIL reset_test got %b exp 0", test); end
        checks++; if (ovf !== 2'b00)      begin errors++; $display("FAIL reset_ovf got %b exp 00", ovf); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0]  d   [4] = '{8'hA5, 8'h3C, 8'h0F, 8'h5A};
        logic [1:0]  m   [4] = '{2'b01, 2'b01, 2'b01, 2'b10};
        logic [10:0] ea  [4] = '{11'd0, 11'd2, 11'd4, 11'd1};
        logic [11:0] ew  [4] = '{12'h528, 12'h1E0, 12'h078, 12'h2D0};
        int n, l0, l1; logic [10:0] a0, a1; logic [11:0] w0, w1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pulse_watch(m[i], {d[i], d[i]}, 4, 100, n, l0, l1, a0, a1, w0, w1);
            checks++; if (n !== 1)      begin errors++; $display("FAIL basic_we_count[%0d] got %0d exp 1", i, n); end
            checks++; if (a0 !== ea[i]) begin errors++; $display("FAIL basic_addr[%0d] got %0d exp %0d", i, a0, ea[i]); end
            checks++; if (w0 !== ew[i]) begin errors++; $display("FAIL basic_word[%0d] got %h exp %h", i, w0, ew[i]); end
            checks++; if (l0 !== LAT)   begin errors++; $display("FAIL basic_latency[%0d] got %0d exp %0d", i, l0, LAT); end
        end
    endtask

    task automatic test_skip();
        int n, l0, l1; logic [10:0] a0, a1; logic [11:0] w0, w1;
        int exp_n; int exp_a;
        do_reset();
        for (int k = 1; k <= 22; k++) begin
            pulse_watch(2'b01, {8'h00, 8'(k)}, 4, 40, n, l0, l1, a0, a1, w0, w1);
            exp_n = (k == 17 || k == 18) ? 0 : 1;
            exp_a = (k <= 16) ? 2 * (k - 1) : 32 + 2 * (k - 19);
            checks++; if (n !== exp_n) begin errors++; $display("FAIL skip_we_count[%0d] got %0d exp %0d", k, n, exp_n); end
            if (exp_n == 1) begin
                checks++; if (a0 !== 11'(exp_a)) begin errors++; $display("FAIL skip_addr[%0d] got %0d exp %0d", k, a0, exp_a); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n, l0, l1; logic [10:0] a0, a1; logic [11:0] w0, w1;
        do_reset();
        pulse_watch(2'b11, 16'hC3_A5, 4, 40, n, l0, l1, a0, a1, w0, w1);
        checks++; if (n !== 2)        begin errors++; $display("FAIL pair1_we_count got %0d exp 2", n); end
        checks++; if (a0 !== 11'd0)   begin errors++; $display("FAIL pair1_first_addr got %0d exp 0", a0); end
        checks++; if (l0 !== LAT)     begin errors++; $display("FAIL pair1_first_lat got %0d exp %0d", l0, LAT); end
        checks++; if (w0 !== 12'h528) begin errors++; $display("FAIL pair1_first_word got %h exp 528", w0); end
        checks++; if (a1 !== 11'd1)   begin errors++; $display("FAIL pair1_second_addr got %0d exp 1", a1); end
        checks++; if (l1 !== LAT + 1) begin errors++; $display("FAIL pair1_second_lat got %0d exp %0d", l1, LAT + 1); end
        checks++; if (w1 !== 12'h618) begin errors++; $display("FAIL pair1_second_word got %h exp 618", w1); end
        // A lone ch0 write leaves ch1 with top priority for the next contended pair.
        pulse_watch(2'b01, 16'h00_11, 4, 40, n, l0, l1, a0, a1, w0, w1);
        checks++; if (a0 !== 11'd2)   begin errors++; $display("FAIL single_addr got %0d exp 2", a0); end
        pulse_watch(2'b11, 16'h22_33, 4, 40, n, l0, l1, a0, a1, w0, w1);
        checks++; if (n !== 2)        begin errors++; $display("FAIL pair2_we_count got %0d exp 2", n); end
        checks++; if (a0 !== 11'd3)   begin errors++; $display("FAIL pair2_first_addr got %0d exp 3", a0); end
        checks++; if (w0 !== 12'h110) begin errors++; $display("FAIL pair2_first_word got %h exp 110", w0); end
        checks++; if (a1 !== 11'd4)   begin errors++; $display("FAIL pair2_second_addr got %0d exp 4", a1); end
        checks++; if (l1 !== LAT + 1) begin errors++; $display("FAIL pair2_second_lat got %0d exp %0d", l1, LAT + 1); end
    endtask

    task automatic test_long_strobe();
        int n, l0, l1; logic [10:0] a0, a1; logic [11:0] w0, w1;
        do_reset();
        pulse_watch(2'b01, 16'h00_4C, 60, 80, n, l0, l1, a0, a1, w0, w1);
        checks++; if (n !== 1)      begin errors++; $display("FAIL long_we_count got %0d exp 1", n); end
        pulse_watch(2'b01, 16'h00_4D, 4, 40, n, l0, l1, a0, a1, w0, w1);
        checks++; if (a0 !== 11'd2) begin errors++; $display("FAIL long_next_addr got %0d exp 2", a0); end
    endtask

    task automatic test_overflow();
        int n, l0, l1; logic [10:0] a0, a1; logic [11:0] w0, w1;
        do_reset();
        pulse_watch(2'b01, 16'h00_11, 4, 10, n, l0, l1, a0, a1, w0, w1);
        checks++; if (n !== 0)        begin errors++; $display("FAIL ovf_early_we got %0d exp 0", n); end
        pulse_watch(2'b01, 16'h00_22, 4, 50, n, l0, l1, a0, a1, w0, w1);
        checks++; if (n !== 1)        begin errors++; $display("FAIL ovf_we_count got %0d exp 1", n); end
        checks++; if (w0 !== 12'h088) begin errors++; $display("FAIL ovf_word got %h exp 088", w0); end
        checks++; if (a0 !== 11'd0)   begin errors++; $display("FAIL ovf_addr got %0d exp 0", a0); end
        checks++; if (l0 !== LAT - 10) begin errors++; $display("FAIL ovf_lat got %0d exp %0d", l0, LAT - 10); end
        checks++; if (ovf !== 2'b01)  begin errors++; $display("FAIL ovf_flag got %b exp 01", ovf); end
        pulse_watch(2'b01, 16'h00_33, 4, 40, n, l0, l1, a0, a1, w0, w1);
        checks++; if (a0 !== 11'd4)   begin errors++; $display("FAIL ovf_next_addr got %0d exp 4", a0); end
        checks++; if (w0 !== 12'h198) begin errors++; $display("FAIL ovf_next_word got %h exp 198", w0); end
        checks++; if (ovf !== 2'b01)  begin errors++; $display("FAIL ovf_sticky got %b exp 01", ovf); end
    endtask

    // Continues from test_overflow: ch0 has taken 3 words, ovf[0] is set.
    task automatic test_frame_switch();
        int n, l0, l1; logic [10:0] a0, a1; logic [11:0] w0, w1;
        int tcount, wcount;
        pulse_watch(2'b01, 16'h00_44, 4, 40, n, l0, l1, a0, a1, w0, w1);
        checks++; if (a0 !== 11'd6) begin errors++; $display("FAIL sw_pre_addr4 got %0d exp 6", a0); end
        pulse_watch(2'b01, 16'h00_55, 4, 40, n, l0, l1, a0, a1, w0, w1);
        checks++; if (a0 !== 11'd8) begin errors++; $display("FAIL sw_pre_addr5 got %0d exp 8", a0); end
        tcount = 0; wcount = 0;
        @(negedge clk);
        SW = ~SW;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (test) tcount++;
            if (WE) wcount++;
        end
        $display("frame switch: test_cycles=%0d we=%0d ovf=%b", tcount, wcount, ovf);
        checks++; if (tcount !== 1)  begin errors++; $display("FAIL sw_test_pulse got %0d exp 1", tcount); end
        checks++; if (wcount !== 0)  begin errors++; $display("FAIL sw_no_we got %0d exp 0", wcount); end
        checks++; if (ovf !== 2'b00) begin errors++; $display("FAIL sw_ovf_clear got %b exp 00", ovf); end
        pulse_watch(2'b01, 16'h00_66, 4, 40, n, l0, l1, a0, a1, w0, w1);
        checks++; if (a0 !== 11'd0)  begin errors++; $display("FAIL sw_restart_addr got %0d exp 0", a0); end
        checks++; if (l0 !== LAT)    begin errors++; $display("FAIL sw_restart_lat got %0d exp %0d", l0, LAT); end
    endtask

    // Continues from test_frame_switch: ch0 is at word 1 of group 0.
    task automatic test_reset_mid();
        int n, l0, l1; logic [10:0] a0, a1; logic [11:0] w0, w1;
        pulse_watch(2'b01, 16'h00_77, 4, 40, n, l0, l1, a0, a1, w0, w1);
        checks++; if (a0 !== 11'd2) begin errors++; $display("FAIL rst_pre_addr got %0d exp 2", a0); end
        pulse_watch(2'b01, 16'h00_88, 4, 15, n, l0, l1, a0, a1, w0, w1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (WrAddr !== 11'd0)  begin errors++; $display("FAIL rst_mid_addr got %0d exp 0", WrAddr); end
        checks++; if (orbWord !== 12'd0) begin errors++; $display("FAIL rst_mid_word got %h exp 0", orbWord); end
        checks++; if (WE !== 1'b0)       begin errors++; $display("FAIL rst_mid_we got %b exp 0", WE); end
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (WE) n++;
        end
        checks++; if (n !== 0) begin errors++; $display("FAIL rst_lost_pending got %0d exp 0", n); end
        pulse_watch(2'b01, 16'h00_99, 4, 40, n, l0, l1, a0, a1, w0, w1);
        checks++; if (a0 !== 11'd0)   begin errors++; $display("FAIL rst_restart_addr got %0d exp 0", a0); end
        checks++; if (w0 !== 12'h4C8) begin errors++; $display("FAIL rst_restart_word got %h exp 4c8", w0); end
    endtask

    initial begin
        iData = '0;
        strob = '0;
        SW    = 1'b0;
        rst   = 1'b0;
        test_reset();
        test_basic();
        test_skip();
        test_back_to_back();
        test_long_strobe();
        test_overflow();
        test_frame_switch();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
